// File: rtl/matvec_transpose_seq.sv
`default_nettype none
// ============================================================================
// Module   : matvec_transpose_seq
// Brief    : Sequential transposed int8 matrix-vector engine, y = sat8(M^T x).
//            One matrix row per cycle feeds N parallel column accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module matvec_transpose_seq #(
  parameter int N    = 64,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_wr_en,
  input  logic [$clog2(N)-1:0]   i_wr_row,
  input  logic [$clog2(N)-1:0]   i_wr_col,
  input  logic signed [DW-1:0]   i_wr_data,
  output logic                   o_wr_ready,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [N*DW-1:0]        i_in_vector,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [N*DW-1:0]        o_out_vector,
  output logic                   o_busy
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0]          c_LAST_ROW = RW'(N-1);
  localparam logic signed [ACCW-1:0] c_SAT_MAX  = ACCW'((2**(DW-1)) - 1);
  localparam logic signed [ACCW-1:0] c_SAT_MIN  = ACCW'(-(2**(DW-1)));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [RW-1:0]          r_row;
  logic [N*DW-1:0]        r_x;
  logic signed [ACCW-1:0] r_acc [N];
  logic                   r_in_ready;
  logic                   r_wr_ready;
  logic                   r_busy;
  logic                   r_out_valid;
  logic [N*DW-1:0]        r_out_vector;

  // Weight storage: one packed word per matrix row so a whole row reads at once
  logic [N*DW-1:0]        r_mem [N];

  logic [N*DW-1:0]        w_row_data;
  logic signed [DW-1:0]   w_xr;
  logic signed [ACCW-1:0] w_sum [N];
  logic [N*DW-1:0]        w_sat;

  assign w_row_data = r_mem[r_row];
  assign w_xr       = r_x[r_row*DW +: DW];

  // Per-column multiply-accumulate and saturation to the output width
  for (genvar j = 0; j < N; j++) begin : g_col
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    assign w_prod     = $signed(w_row_data[j*DW +: DW]) * w_xr;
    assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_sum[j]   = r_acc[j] + w_prod_ext;
    assign w_sat[j*DW +: DW] = (w_sum[j] > c_SAT_MAX) ? c_SAT_MAX[DW-1:0] :
                               (w_sum[j] < c_SAT_MIN) ? c_SAT_MIN[DW-1:0] :
                               w_sum[j][DW-1:0];
  end

  // Weight write port: no reset so the matrix survives rstn; accepted only in IDLE
  always_ff @(posedge clk) begin
    if (i_wr_en && r_wr_ready) begin
      r_mem[i_wr_row][i_wr_col*DW +: DW] <= i_wr_data;
    end
  end

  // Control FSM with accumulators, row counter and registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_x          <= '0;
      r_in_ready   <= 1'b1;
      r_wr_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_vector <= '0;
      for (int j = 0; j < N; j++) r_acc[j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_x        <= i_in_vector;
            r_row      <= '0;
            r_state    <= S_COMPUTE;
            r_in_ready <= 1'b0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
            for (int j = 0; j < N; j++) r_acc[j] <= '0;
          end
        end
        S_COMPUTE: begin
          for (int j = 0; j < N; j++) r_acc[j] <= w_sum[j];
          if (r_row == c_LAST_ROW) begin
            // Last row: the saturated final sums go straight to the output
            r_out_vector <= w_sat;
            r_out_valid  <= 1'b1;
            r_row        <= '0;
            r_state      <= S_DONE;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_wr_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_wr_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_ready   = r_wr_ready;
  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_out_valid  = r_out_valid;
  assign o_out_vector = r_out_vector;

endmodule
`default_nettype wire

// File: doc/matvec_transpose_seq.md
Name: matvec_transpose_seq

Overview:
- Sequential transposed matrix-vector engine for int8 data: out[j] = sat8(sum over i of M[i][j]*x[i]), i.e. y = M^T x.
- This is the reverse-direction companion of the existing single-cycle saturating M*x block; it serves backward and feedback paths.
- It holds an NxN signed int8 weight matrix loaded through a write port.
- It accepts one vector per valid/ready transaction and processes one matrix row per cycle across N parallel column accumulators.
- It returns the result vector over a valid/ready output.

Parameters:
N, 64, vector length and matrix dimension (rows = columns = N)
DW, 8, signed element width of inputs, weights and outputs
ACCW, 2*DW+$clog2(N), accumulator width (22 at defaults); no wrap is possible

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
wr_en  input  1  weight write strobe
wr_row  input  $clog2(N)  weight row index i
wr_col  input  $clog2(N)  weight column index j
wr_data  input  DW signed  weight value M[i][j]
wr_ready  output  1  weight write accepted this cycle
in_valid  input  1  input vector valid
in_ready  output  1  engine can accept a vector
in_vector  input  N x DW signed  input vector x[0..N-1]
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts the result
out_vector  output  N x DW signed  result y[0..N-1]
busy  output  1  high in COMPUTE or DONE

Behaviour:
- Reset (async assert, sync-style deassert on clk):
  - state=IDLE; out_valid=0; out_vector all 0; busy=0; row counter=0; accumulators=0.
  - The weight matrix has no reset and its contents survive rstn.
- States:
  - IDLE: in_ready=1, wr_ready=1, busy=0.
  - COMPUTE: in_ready=0, wr_ready=0, busy=1.
  - DONE: in_ready=0, wr_ready=0, busy=1, out_valid=1.
- Weight writes:
  - Take effect on the clk edge when wr_en && wr_ready, so only in IDLE.
  - wr_en outside IDLE is ignored: matrix unchanged, no queuing.
- IDLE -> COMPUTE on an edge with in_valid && in_ready (accept edge k):
  - in_vector is latched into an internal x register.
  - All N accumulators clear; row=0.
  - in_vector may change after edge k.
- COMPUTE, edge k+1+r for r = 0..N-1:
  - acc[j] += M[r][j]*x[r] for all j in parallel.
  - Products are signed full-precision (2*DW), sign-extended to ACCW.
  - row increments each edge.
- Completion at edge k+N, when row==N-1 is processed:
  - Each out_vector[j] registers sat(acc[j]+M[N-1][j]*x[N-1]).
  - Saturation: a value >127 gives 127; a value <-128 gives -128; otherwise the low DW bits.
  - State goes to DONE, out_valid=1 and row resets to 0.
  - Latency: out_valid is first high in the cycle after edge k+N, i.e. N cycles after acceptance.
- DONE:
  - out_vector and out_valid are held stable until an edge with out_ready=1.
  - That edge moves the state to IDLE with out_valid=0; out_vector keeps its last value.
  - A new vector can be accepted at the earliest on the edge after returning to IDLE; there is no overlap.
  - Throughput is at most one vector per N+2 cycles.
- in_valid in COMPUTE or DONE is ignored; the upstream must hold it until in_ready.
- Reset mid-COMPUTE or mid-DONE aborts the operation: outputs return to reset values and the partial result is discarded.
- N must be a power of two ≥2; the row counter wraps from N-1 to 0 only via the completion transition.

Test Plan:
- Identity weights (M[i][i]=1, else 0); x[i]=i-32 -> out_vector[i]=i-32 for all i; out_valid rises exactly 64 cycles after the accept edge.
- Transpose check: M all 0 except M[2][5]=3; x[2]=4, other x=1 -> out[5]=12, all other outputs 0 (out[2] must be 0).
- Saturation: M all 127 with x all 127 -> every out=127. M all -128 with x all 127 -> every out=-128. M all 1 with x[0..3]=100,100,-100,-70 and the rest 0 -> out=30 everywhere, which exercises the ±intermediate range with no wrap.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_vector stable, in_ready=0, busy=1. Raise out_ready -> IDLE next cycle and a second vector is accepted the cycle after.
- Write lockout: pulse wr_en with M[0][0]=50 during COMPUTE -> current and next results unaffected and M[0][0] keeps its old value. The same write in IDLE takes effect on the next vector.
- Reset mid-COMPUTE at row 30 -> out_valid=0, out_vector all 0, in_ready=1 after reset release; the weights still produce correct results on the next vector.
